// File: rtl/jtag_dbg_pkg.sv
// Shared constants and helpers for the system-clock JTAG debug command path.
package jtag_dbg_pkg;

   localparam int SR_W_DEF    = 38;
   localparam int IR_W_DEF    = 2;
   localparam int ACT_BIT_DEF = 34;

   // Channel indices carried on cmd_ch / one-hot decode positions
   localparam int CH_OCIMEM    = 0;
   localparam int CH_TRACEMEM  = 1;
   localparam int CH_BREAK     = 2;
   localparam int CH_TRACECTRL = 3;

   // Ceiling log2 for elaboration-time width calculation
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/jtag_cmd_fifo.sv
// Show-ahead command FIFO with a registered head view, exact level and full/empty.
// The head register is refreshed from the pre-edge state, so a push into an empty
// FIFO becomes visible one cycle after it is written.
module jtag_cmd_fifo
   import jtag_dbg_pkg::*;
#(
   parameter  int W     = 40,
   parameter  int DEPTH = 4,
   localparam int AW    = clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  logic [W-1:0]  din_i,
   input  logic          pop_i,
   output logic [W-1:0]  dout_o,
   output logic          valid_o,
   output logic [LW-1:0] level_o,
   output logic          full_o,
   output logic          empty_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_nxt;
   logic [LW-1:0] count_q, count_d;
   logic [W-1:0]  dout_q, dout_d;
   logic          valid_q, valid_d;
   logic          push_ok, pop_ok;

   assign full_o  = (count_q == LW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign pop_ok  = pop_i & valid_q;
   assign push_ok = push_i & (~full_o | pop_ok);
   assign rd_nxt  = rd_ptr_q + 1'b1;

   // Next occupancy and next head view (head after this edge's pop, ignoring this edge's push)
   always_comb begin
      count_d = count_q;
      if (push_ok && !pop_ok)
         count_d = count_q + 1'b1;
      else if (!push_ok && pop_ok)
         count_d = count_q - 1'b1;

      if (pop_ok) begin
         valid_d = (count_q >= LW'(2));
         dout_d  = valid_d ? mem_q[rd_nxt] : dout_q;
      end else begin
         valid_d = ~empty_o;
         dout_d  = valid_d ? mem_q[rd_ptr_q] : dout_q;
      end
   end

   // Storage array, written at the tail on an accepted push
   always_ff @(posedge clk_i) begin
      if (push_ok)
         mem_q[wr_ptr_q] <= din_i;
   end

   // Pointers, count and registered head
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_nxt;
         count_q <= count_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
      end
   end

   assign dout_o  = dout_q;
   assign valid_o = valid_q;
   assign level_o = count_q;

endmodule

// File: rtl/jtag_debug_cmd_sysclk_mc.sv
// System-clock side of the CPU JTAG debug link: synchronises update-DR/IR strobes,
// captures {channel, shift register} commands into a FIFO and decodes the head.
module jtag_debug_cmd_sysclk_mc
   import jtag_dbg_pkg::*;
#(
   parameter  int SR_W        = SR_W_DEF,
   parameter  int IR_W        = IR_W_DEF,
   parameter  int ACT_BIT     = ACT_BIT_DEF,
   parameter  int SYNC_STAGES = 2,
   parameter  int FIFO_DEPTH  = 4,
   localparam int CH          = 2 ** IR_W,
   localparam int LVL_W       = clog2(FIFO_DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [SR_W-1:0]  sr,
   input  logic [IR_W-1:0]  ir_in,
   input  logic             vs_udr,
   input  logic             vs_uir,
   input  logic             cmd_ready,
   input  logic             clr_ovf,
   output logic             cmd_valid,
   output logic [SR_W-1:0]  cmd_data,
   output logic [IR_W-1:0]  cmd_ch,
   output logic [CH-1:0]    act_onehot,
   output logic [CH-1:0]    noact_onehot,
   output logic [IR_W-1:0]  ir_lat,
   output logic             ir_upd,
   output logic [LVL_W-1:0] fifo_level,
   output logic             ovf
);

   logic [SYNC_STAGES-1:0] udr_sync_q, uir_sync_q;
   logic                   udr_edge_q, uir_edge_q;
   logic                   udr_rise, uir_rise;
   logic [IR_W-1:0]        ir_lat_q;
   logic                   ir_upd_q;
   logic                   ovf_q;
   logic [IR_W-1:0]        push_ch;
   logic                   pop;
   logic                   fifo_full, fifo_empty;
   logic [IR_W+SR_W-1:0]   fifo_dout;

   // Strobe synchronisers and edge flops; preset high so a strobe held through reset is not an event
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         udr_sync_q <= '1;
         uir_sync_q <= '1;
         udr_edge_q <= 1'b1;
         uir_edge_q <= 1'b1;
      end else begin
         udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
         uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
         udr_edge_q <= udr_sync_q[SYNC_STAGES-1];
         uir_edge_q <= uir_sync_q[SYNC_STAGES-1];
      end
   end

   assign udr_rise = udr_sync_q[SYNC_STAGES-1] & ~udr_edge_q;
   assign uir_rise = uir_sync_q[SYNC_STAGES-1] & ~uir_edge_q;

   // A same-cycle IR update must steer the DR command before ir_lat_q catches up
   assign push_ch = uir_rise ? ir_in : ir_lat_q;
   assign pop     = cmd_valid & cmd_ready & ~fifo_empty;

   // IR latch, update pulse and sticky overflow (set beats clear)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ir_lat_q <= '0;
         ir_upd_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         ir_upd_q <= uir_rise;
         if (uir_rise)
            ir_lat_q <= ir_in;
         if (udr_rise && fifo_full && !pop)
            ovf_q <= 1'b1;
         else if (clr_ovf)
            ovf_q <= 1'b0;
      end
   end

   jtag_cmd_fifo #(
      .W     (IR_W + SR_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (reset),
      .push_i  (udr_rise),
      .din_i   ({push_ch, sr}),
      .pop_i   (pop),
      .dout_o  (fifo_dout),
      .valid_o (cmd_valid),
      .level_o (fifo_level),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign cmd_ch   = fifo_dout[IR_W+SR_W-1:SR_W];
   assign cmd_data = fifo_dout[SR_W-1:0];

   // Action / no-action one-hot decode of the registered head
   always_comb begin
      act_onehot   = '0;
      noact_onehot = '0;
      if (cmd_valid) begin
         if (cmd_data[ACT_BIT])
            act_onehot[cmd_ch] = 1'b1;
         else
            noact_onehot[cmd_ch] = 1'b1;
      end
   end

   assign ir_lat = ir_lat_q;
   assign ir_upd = ir_upd_q;
   assign ovf    = ovf_q;

endmodule
